// File: rtl/spi_tx_scheduler.sv
// Round-robin scheduler that shares one SPI mode-0 transmit master between N_REQ requesters.
// Each transfer runs grant -> start pulse -> wait for completion or timeout -> inter-frame gap.
module spi_tx_scheduler #(
    parameter int N_REQ     = 4,
    parameter int DATA_LEN  = 8,
    parameter int START_CYC = 2,
    parameter int GAP_CYC   = 4,
    parameter int TIMEOUT   = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_LEN-1:0] req_data,
    output logic [N_REQ-1:0]          ack,
    output logic                      m_tx_en,
    output logic                      m_start,
    output logic [DATA_LEN-1:0]       m_din,
    input  logic                      m_qvld,
    output logic [N_REQ-1:0]          sel,
    output logic                      busy,
    output logic                      err,
    output logic [2:0]                err_id
);

    localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SCNT_W = $clog2(START_CYC + 1);
    localparam int GCNT_W = $clog2(GAP_CYC + 1);

    localparam logic [SCNT_W-1:0] START_LAST = SCNT_W'(START_CYC - 1);
    localparam logic [GCNT_W-1:0] GAP_LAST   = GCNT_W'(GAP_CYC - 1);
    localparam logic [15:0]       TIMER_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    gnt_q, gnt_d;
    logic [SCNT_W-1:0]   start_cnt_q, start_cnt_d;
    logic [GCNT_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [15:0]         timer_q, timer_d;
    logic                qvld_dly_q, qvld_dly_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic                m_tx_en_q, m_tx_en_d;
    logic                m_start_q, m_start_d;
    logic [DATA_LEN-1:0] m_din_q, m_din_d;
    logic [N_REQ-1:0]    sel_q, sel_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic [2:0]          err_id_q, err_id_d;

    logic [DATA_LEN-1:0] words [N_REQ];
    logic                gnt_found;
    logic [PTR_W-1:0]    gnt_win;
    logic [PTR_W-1:0]    cand;
    logic                qvld_edge;

    for (genvar i = 0; i < N_REQ; i++) begin : g_words
        assign words[i] = req_data[i*DATA_LEN +: DATA_LEN];
    end

    // Index addition modulo N_REQ; both operands stay below N_REQ so one subtraction suffices.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] a,
                                                  input logic [PTR_W:0]   b);
        logic [PTR_W+1:0] s;
        s = {2'b00, a} + {1'b0, b};
        if (s >= (PTR_W+2)'(N_REQ)) begin
            s = s - (PTR_W+2)'(N_REQ);
        end
        return s[PTR_W-1:0];
    endfunction

    assign qvld_edge = m_qvld & ~qvld_dly_q;

    // First requester at or after the pointer, scanning with wrap-around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_win   = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = wrap_add(ptr_q, (PTR_W+1)'(k));
            if (!gnt_found && req[cand]) begin
                gnt_found = 1'b1;
                gnt_win   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        start_cnt_d = start_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        timer_d     = timer_q;
        qvld_dly_d  = m_qvld;
        ack_d       = '0;
        m_tx_en_d   = 1'b1;
        m_start_d   = m_start_q;
        m_din_d     = m_din_q;
        sel_d       = sel_q;
        busy_d      = busy_q;
        err_d       = 1'b0;
        err_id_d    = err_id_q;

        case (state_q)
            S_IDLE: begin
                if (en && gnt_found) begin
                    m_din_d        = words[gnt_win];
                    sel_d          = '0;
                    sel_d[gnt_win] = 1'b1;
                    busy_d         = 1'b1;
                    m_start_d      = 1'b1;
                    gnt_d          = gnt_win;
                    ptr_d          = wrap_add(gnt_win, (PTR_W+1)'(1));
                    start_cnt_d    = '0;
                    state_d        = S_START;
                end
            end

            S_START: begin
                if (start_cnt_q == START_LAST) begin
                    m_start_d = 1'b0;
                    timer_d   = '0;
                    state_d   = S_WAIT_DONE;
                end else begin
                    start_cnt_d = start_cnt_q + SCNT_W'(1);
                end
            end

            // A completion edge takes priority over a timeout landing on the same cycle.
            S_WAIT_DONE: begin
                if (qvld_edge) begin
                    ack_d[gnt_q] = 1'b1;
                    sel_d        = '0;
                    gap_cnt_d    = '0;
                    state_d      = S_GAP;
                end else if (timer_q == TIMER_LAST) begin
                    err_d     = 1'b1;
                    err_id_d  = 3'(gnt_q);
                    sel_d     = '0;
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GCNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            start_cnt_q <= '0;
            gap_cnt_q   <= '0;
            timer_q     <= '0;
            qvld_dly_q  <= 1'b0;
            ack_q       <= '0;
            m_tx_en_q   <= 1'b0;
            m_start_q   <= 1'b0;
            m_din_q     <= '0;
            sel_q       <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            err_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            start_cnt_q <= start_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            timer_q     <= timer_d;
            qvld_dly_q  <= qvld_dly_d;
            ack_q       <= ack_d;
            m_tx_en_q   <= m_tx_en_d;
            m_start_q   <= m_start_d;
            m_din_q     <= m_din_d;
            sel_q       <= sel_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            err_id_q    <= err_id_d;
        end
    end

    assign ack     = ack_q;
    assign m_tx_en = m_tx_en_q;
    assign m_start = m_start_q;
    assign m_din   = m_din_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign err     = err_q;
    assign err_id  = err_id_q;

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Directed plus randomized bench for spi_tx_scheduler; a round-robin model and an
// in-line SPI master stand-in supply the expected grants, words and timings.
module tb_spi_tx_scheduler;

    localparam int N_REQ     = 4;
    localparam int DATA_LEN  = 8;
    localparam int START_CYC = 2;
    localparam int GAP_CYC   = 4;
    localparam int TIMEOUT   = 1023;

    localparam int MODE_DROP   = 0;
    localparam int MODE_HOLD   = 1;
    localparam int MODE_SILENT = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      en;
    logic [N_REQ-1:0]          req;
    logic [N_REQ*DATA_LEN-1:0] req_data;
    logic [N_REQ-1:0]          ack;
    logic                      m_tx_en;
    logic                      m_start;
    logic [DATA_LEN-1:0]       m_din;
    logic                      m_qvld;
    logic [N_REQ-1:0]          sel;
    logic                      busy;
    logic                      err;
    logic [2:0]                err_id;

    logic [DATA_LEN-1:0] words [N_REQ];

    int checks    = 0;
    int errors    = 0;
    int model_ptr = 0;

    for (genvar i = 0; i < N_REQ; i++) begin : g_pack
        assign req_data[i*DATA_LEN +: DATA_LEN] = words[i];
    end

    spi_tx_scheduler #(
        .N_REQ    (N_REQ),
        .DATA_LEN (DATA_LEN),
        .START_CYC(START_CYC),
        .GAP_CYC  (GAP_CYC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .req_data(req_data),
        .ack     (ack),
        .m_tx_en (m_tx_en),
        .m_start (m_start),
        .m_din   (m_din),
        .m_qvld  (m_qvld),
        .sel     (sel),
        .busy    (busy),
        .err     (err),
        .err_id  (err_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first set request at or after the pointer, modulo N_REQ.
    function automatic int model_pick(input logic [N_REQ-1:0] r);
        for (int k = 0; k < N_REQ; k++) begin
            if (r[(model_ptr + k) % N_REQ]) return (model_ptr + k) % N_REQ;
        end
        return -1;
    endfunction

    task automatic randomize_words();
        for (int i = 0; i < N_REQ; i++) words[i] = DATA_LEN'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_ack"},     32'(ack),     32'd0);
        check_output({tag, "_tx_en"},   32'(m_tx_en), 32'd0);
        check_output({tag, "_start"},   32'(m_start), 32'd0);
        check_output({tag, "_din"},     32'(m_din),   32'd0);
        check_output({tag, "_sel"},     32'(sel),     32'd0);
        check_output({tag, "_busy"},    32'(busy),    32'd0);
        check_output({tag, "_err"},     32'(err),     32'd0);
        check_output({tag, "_err_id"},  32'(err_id),  32'd0);
    endtask

    // One complete transfer from IDLE; the caller has req/words/en set up already.
    task automatic apply_stimulus(input int mode, input int delay, input bit drop_en,
                                  output int grant_cycles);
        int  exp_g;
        int  n;
        bit  early;
        bit  sel_bad;
        exp_g = model_pick(req);
        n = 0;
        do begin
            tick();
            n++;
        end while (busy !== 1'b1 && n < 40);
        grant_cycles = n;
        check_output("grant_seen", 32'(busy), 32'd1);
        if (exp_g < 0) exp_g = 0;
        model_ptr = (exp_g + 1) % N_REQ;
        check_output("grant_sel",   32'(sel),     32'(1) << exp_g);
        check_output("grant_din",   32'(m_din),   32'(words[exp_g]));
        check_output("start_rise",  32'(m_start), 32'd1);

        n = 0;
        while (m_start === 1'b1 && n < START_CYC + 10) begin
            n++;
            tick();
        end
        check_output("start_width", 32'(n),     32'(START_CYC));
        check_output("din_stable",  32'(m_din), 32'(words[exp_g]));
        if (drop_en) en = 1'b0;

        if (mode == MODE_SILENT) begin
            n = 0;
            while (err !== 1'b1 && n < TIMEOUT + 20) begin
                tick();
                n++;
            end
            check_output("timeout_cycles", 32'(n),      32'(TIMEOUT));
            check_output("timeout_err_id", 32'(err_id), 32'(exp_g));
            check_output("timeout_no_ack", 32'(ack),    32'd0);
        end else begin
            early = 1'b0;
            repeat (delay) begin
                tick();
                if (ack !== '0 || err !== 1'b0 || sel !== N_REQ'(1 << exp_g)) early = 1'b1;
            end
            check_output("wait_quiet", 32'(early), 32'd0);
            m_qvld = 1'b1;
            tick();
            check_output("ack_pulse", 32'(ack), 32'(1) << exp_g);
            check_output("ack_no_err", 32'(err), 32'd0);
            if (mode == MODE_DROP) m_qvld = 1'b0;
        end

        check_output("gap_sel_entry", 32'(sel), 32'd0);
        tick();
        check_output("ack_one_cycle", 32'(ack), 32'd0);
        check_output("err_one_cycle", 32'(err), 32'd0);
        if (mode == MODE_SILENT) check_output("err_id_held", 32'(err_id), 32'(exp_g));

        n = 1;
        sel_bad = 1'b0;
        while (busy === 1'b1 && n < GAP_CYC + 20) begin
            if (sel !== '0) sel_bad = 1'b1;
            tick();
            n++;
        end
        check_output("gap_len",      32'(n),       32'(GAP_CYC));
        check_output("gap_sel_zero", 32'(sel_bad), 32'd0);
    endtask

    initial begin
        int  gc;
        int  n;
        bit  flag;

        rst    = 1'b0;
        en     = 1'b0;
        req    = '0;
        m_qvld = 1'b0;
        for (int i = 0; i < N_REQ; i++) words[i] = '0;

        $display("[TB] reset");
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();
        check_output("tx_en_out_of_reset", 32'(m_tx_en), 32'd1);

        $display("[TB] single transfer");
        randomize_words();
        words[0] = 8'hA5;
        en  = 1'b1;
        req = 4'b0001;
        apply_stimulus(MODE_DROP, 20, 1'b0, gc);
        check_output("single_grant_latency", 32'(gc), 32'd1);
        req = '0;

        $display("[TB] round robin");
        rst = 1'b0;
        tick();
        rst = 1'b1;
        model_ptr = 0;
        randomize_words();
        req = 4'b1111;
        for (int t = 0; t < 4; t++) begin
            apply_stimulus(MODE_DROP, int'($urandom_range(0, 25)), 1'b0, gc);
        end
        req = 4'b0101;
        apply_stimulus(MODE_DROP, int'($urandom_range(0, 25)), 1'b0, gc);
        apply_stimulus(MODE_DROP, int'($urandom_range(0, 25)), 1'b0, gc);

        $display("[TB] stale qvld");
        randomize_words();
        req = 4'b0100;
        apply_stimulus(MODE_HOLD, int'($urandom_range(0, 25)), 1'b0, gc);
        apply_stimulus(MODE_SILENT, 0, 1'b0, gc);
        m_qvld = 1'b0;
        req = '0;

        $display("[TB] timeout then retry");
        randomize_words();
        req = 4'b0010;
        apply_stimulus(MODE_SILENT, 0, 1'b0, gc);
        apply_stimulus(MODE_DROP, int'($urandom_range(0, 25)), 1'b0, gc);
        req = '0;

        $display("[TB] enable gating");
        randomize_words();
        en   = 1'b0;
        req  = 4'b0100;
        flag = 1'b0;
        repeat (50) begin
            tick();
            if (busy !== 1'b0 || sel !== '0) flag = 1'b1;
        end
        check_output("en_low_no_grant", 32'(flag), 32'd0);
        en = 1'b1;
        apply_stimulus(MODE_DROP, int'($urandom_range(0, 25)), 1'b1, gc);
        check_output("en_high_grant_latency", 32'(gc), 32'd1);
        en  = 1'b1;
        req = '0;

        $display("[TB] randomized transfers");
        for (int t = 0; t < 6; t++) begin
            randomize_words();
            req = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            apply_stimulus(MODE_DROP, int'($urandom_range(0, 25)), 1'b0, gc);
        end
        req = '0;

        $display("[TB] reset mid-transfer");
        randomize_words();
        req = 4'b0010;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy !== 1'b1 && n < 40);
        check_output("mid_reset_grant", 32'(sel), 32'(4'b0010 << 0) & 32'(1 << model_pick(req)));
        repeat (START_CYC + 3) tick();
        rst = 1'b0;
        req = '0;
        tick();
        check_reset_outputs("mid_reset");
        rst    = 1'b1;
        m_qvld = 1'b1;
        flag   = 1'b0;
        repeat (5) begin
            tick();
            if (ack !== '0 || busy !== 1'b0) flag = 1'b1;
        end
        check_output("mid_reset_no_ack", 32'(flag), 32'd0);
        m_qvld    = 1'b0;
        model_ptr = 0;
        req = 4'b1000;
        apply_stimulus(MODE_DROP, int'($urandom_range(0, 25)), 1'b0, gc);
        req = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
